// File: rtl/aes_128_kat_bist.sv
// Purpose : known-answer self-test engine that streams a vector table through a pipelined aes_128 core and scores the results.
// Latency : done rises NUM_VEC + LATENCY cycles after start is accepted (earlier on the first miss when stopping on fail).
// Backpressure: none; vectors issue one per clock, start while busy is ignored, optional macro AES_KAT_STOP_ON_FAIL_EN.
module aes_128_kat_bist #(
    parameter int NUM_VEC = 4,
    parameter int LATENCY = 20,
    parameter int IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IDX_W-1:0]   vec_idx,
    input  logic [127:0]       vec_state,
    input  logic [127:0]       vec_key,
    output logic [IDX_W-1:0]   exp_idx,
    input  logic [127:0]       exp_out,
    output logic [127:0]       aes_state,
    output logic [127:0]       aes_key,
    input  logic [127:0]       aes_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [IDX_W-1:0]   first_fail
);

`ifdef AES_KAT_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                          state;

    // Valid/index delay line that tracks each issued vector until its ciphertext emerges.
    logic [LATENCY-1:0]              dl_vld;
    logic [LATENCY-1:0][IDX_W-1:0]   dl_idx;

    logic                            tail_vld;
    logic [IDX_W-1:0]                tail_idx;
    logic                            checking;
    logic                            mismatch;
    logic                            last_chk;
    logic                            abort;
    logic [CNT_W-1:0]                err_cnt_next;

    assign tail_vld = dl_vld[LATENCY-1];
    assign tail_idx = dl_idx[LATENCY-1];

    // The check-side ROM port follows the delay-line tail whenever a result is due.
    assign exp_idx  = tail_vld ? tail_idx : '0;

    // Results only count while a run is active; a reset or abort empties the line anyway.
    assign checking = tail_vld && ((state == ST_ISSUE) || (state == ST_DRAIN));
    assign mismatch = checking && (aes_out != exp_out);
    assign last_chk = checking && (tail_idx == LAST_IDX);

    // Early termination only exists in the stop-on-fail build.
    assign abort    = STOP_ON_FAIL && mismatch;

    // Saturating error count as it will be after this edge; pass is derived from it so a
    // mismatch on the final vector is already included when the run closes.
    always_comb begin
        err_cnt_next = err_cnt;
        if (mismatch && (err_cnt != '1)) begin
            err_cnt_next = err_cnt + CNT_W'(1);
        end
    end

    // Datapath: register the vector into the core and push its tag into the delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            aes_state <= '0;
            aes_key   <= '0;
            dl_vld    <= '0;
            dl_idx    <= '0;
        end else begin
            if ((state == ST_ISSUE) && !abort) begin
                aes_state <= vec_state;
                aes_key   <= vec_key;
            end else begin
                aes_state <= '0;
                aes_key   <= '0;
            end
            dl_vld[0] <= (state == ST_ISSUE) && !abort;
            dl_idx[0] <= vec_idx;
            for (int i = 1; i < LATENCY; i++) begin
                dl_vld[i] <= dl_vld[i-1] && !abort;
                dl_idx[i] <= dl_idx[i-1];
            end
        end
    end

    // Control FSM with registered status outputs and result scoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
        end else begin
            // Scoring runs in parallel with issue whenever LATENCY is shorter than the table.
            if (checking) begin
                err_cnt <= err_cnt_next;
                // A saturating counter never returns to zero, so zero means no miss yet.
                if (mismatch && (err_cnt == '0)) begin
                    first_fail <= tail_idx;
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_ISSUE;
                        vec_idx    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        first_fail <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (vec_idx == LAST_IDX) begin
                        vec_idx <= '0;
                        state   <= ST_DRAIN;
                    end else begin
                        vec_idx <= vec_idx + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (last_chk) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt_next == '0);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // First miss in the stop-on-fail build closes the run immediately.
            if (abort) begin
                state   <= ST_DONE;
                vec_idx <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_128_kat_bist.sv
module tb_aes_128_kat_bist;

    localparam int LAT = 20;
    localparam int NV  = 4;

`ifdef AES_KAT_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- four-vector instance (CNT_W=2 to reach saturation) ----------------
    logic         m_start;
    logic [1:0]   m_vec_idx, m_exp_idx, m_first_fail, m_err_cnt;
    logic [127:0] m_vec_state, m_vec_key, m_exp_out, m_aes_state, m_aes_key, m_aes_out;
    logic         m_busy, m_done, m_pass;
    logic [127:0] m_pt [NV];
    logic [127:0] m_key [NV];
    logic [127:0] m_exp [NV];

    assign m_vec_state = m_pt[m_vec_idx];
    assign m_vec_key   = m_key[m_vec_idx];
    assign m_exp_out   = m_exp[m_exp_idx];

    aes_128_kat_bist #(.NUM_VEC(NV), .LATENCY(LAT), .CNT_W(2)) u_dut (
        .clk(clk), .rst(rst), .start(m_start),
        .vec_idx(m_vec_idx), .vec_state(m_vec_state), .vec_key(m_vec_key),
        .exp_idx(m_exp_idx), .exp_out(m_exp_out),
        .aes_state(m_aes_state), .aes_key(m_aes_key), .aes_out(m_aes_out),
        .busy(m_busy), .done(m_done), .pass(m_pass),
        .err_cnt(m_err_cnt), .first_fail(m_first_fail)
    );

    // ---------------- single-vector instance ----------------
    logic         o_start;
    logic [0:0]   o_vec_idx, o_exp_idx, o_first_fail;
    logic [7:0]   o_err_cnt;
    logic [127:0] o_aes_state, o_aes_key, o_aes_out;
    logic         o_busy, o_done, o_pass;
    logic [127:0] o_pt, o_key, o_exp;

    aes_128_kat_bist #(.NUM_VEC(1), .LATENCY(LAT), .CNT_W(8)) u_one (
        .clk(clk), .rst(rst), .start(o_start),
        .vec_idx(o_vec_idx), .vec_state(o_pt), .vec_key(o_key),
        .exp_idx(o_exp_idx), .exp_out(o_exp),
        .aes_state(o_aes_state), .aes_key(o_aes_key), .aes_out(o_aes_out),
        .busy(o_busy), .done(o_done), .pass(o_pass),
        .err_cnt(o_err_cnt), .first_fail(o_first_fail)
    );

    // ---------------- behavioural AES-128 ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] rk [16];
        logic [7:0] t [16];
        logic [7:0] rc;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8] ^ rk[i];
        end
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            t[0] = sbox[rk[13]] ^ rc;
            t[1] = sbox[rk[14]];
            t[2] = sbox[rk[15]];
            t[3] = sbox[rk[12]];
            for (int i = 0; i < 4; i++)  rk[i] = rk[i] ^ t[i];
            for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
            rc = xt(rc);
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    t[4*c+rw] = sbox[s[4*((c+rw)%4)+rw]];
            for (int c = 0; c < 4; c++) begin
                logic [7:0] a0, a1, a2, a3;
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    // Core stand-in: result appears LAT cycles after the engine registers a vector.
    logic [LAT-2:0][127:0] m_pipe;
    logic [LAT-2:0][127:0] o_pipe;
    always @(posedge clk) begin
        m_pipe <= {m_pipe[LAT-3:0], aes_enc(m_aes_state, m_aes_key)};
        o_pipe <= {o_pipe[LAT-3:0], aes_enc(o_aes_state, o_aes_key)};
    end
    assign m_aes_out = m_pipe[LAT-2];
    assign o_aes_out = o_pipe[LAT-2];

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic load_main(input logic [3:0] corrupt);
        for (int i = 0; i < NV; i++) begin
            m_pt[i]  = {$urandom, $urandom, $urandom, $urandom};
            m_key[i] = {$urandom, $urandom, $urandom, $urandom};
            m_exp[i] = aes_enc(m_pt[i], m_key[i]) ^ 128'(corrupt[i]);
        end
    endtask

    // Expected outcome of a run over the current table, from the rules of the self-test.
    task automatic model_main(output int e_err, output int e_ff, output bit e_pass,
                              output int e_lat, output int e_lim);
        int cnt = 0;
        bit found = 1'b0;
        e_ff = 0;
        for (int i = 0; i < NV; i++) begin
            if (aes_enc(m_pt[i], m_key[i]) != m_exp[i]) begin
                if (!found) e_ff = i;
                found = 1'b1;
                cnt++;
            end
        end
        e_pass = !found;
        if (STOP) begin
            e_err = found ? 1 : 0;
            e_lat = found ? e_ff + 1 + LAT : NV + LAT;
            e_lim = found ? e_ff : NV - 1;
        end else begin
            e_err = (cnt > 3) ? 3 : cnt;
            e_lat = NV + LAT;
            e_lim = NV - 1;
        end
    endtask

    task automatic run_main(input bit poke, input bit started);
        int c, e_err, e_ff, e_lat, e_lim;
        bit e_pass;
        model_main(e_err, e_ff, e_pass, e_lat, e_lim);
        if (!started) begin
            @(negedge clk);
            m_start = 1'b1;
        end
        @(negedge clk);
        m_start = 1'b0;
        check_eq("busy_run", m_busy, 1);
        check_eq("done_clr", m_done, 0);
        c = 0;
        while (!m_done && c < 300) begin
            if (c < NV) check_eq("vec_idx", m_vec_idx, c);
            if (c >= 1 && c <= NV) begin
                check_eq("aes_state", m_aes_state, m_pt[c-1]);
                check_eq("aes_key", m_aes_key, m_key[c-1]);
            end
            if (c >= LAT && c - LAT <= e_lim) check_eq("exp_idx", m_exp_idx, c - LAT);
            m_start = poke && (c == 1 || c == 3);
            @(negedge clk);
            c++;
        end
        m_start = 1'b0;
        check_eq("done_lat", c, e_lat);
        check_eq("pass", m_pass, e_pass);
        check_eq("err_cnt", m_err_cnt, e_err);
        check_eq("first_fail", m_first_fail, e_ff);
        check_eq("busy_end", m_busy, 0);
    endtask

    task automatic run_one(input bit corrupt);
        int c;
        o_pt  = 128'h3243f6a8885a308d313198a2e0370734;
        o_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        o_exp = 128'h3925841d02dc09fbdc118597196a0b32 ^ 128'(corrupt);
        @(negedge clk);
        o_start = 1'b1;
        @(negedge clk);
        o_start = 1'b0;
        c = 0;
        while (!o_done && c < 300) begin
            if (c < 3) check_eq("one_vec_idx", o_vec_idx, 0);
            @(negedge clk);
            c++;
        end
        check_eq("one_done_lat", c, 1 + LAT);
        check_eq("one_pass", o_pass, !corrupt);
        check_eq("one_err_cnt", o_err_cnt, corrupt);
        check_eq("one_first_fail", o_first_fail, 0);
    endtask

    initial begin
        m_start = 1'b0;
        o_start = 1'b0;
        build_sbox();
        load_main(4'b0000);
        o_pt = '0; o_key = '0; o_exp = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", m_busy, 0);
        check_eq("rst_done", m_done, 0);
        check_eq("rst_pass", m_pass, 0);
        check_eq("rst_err", m_err_cnt, 0);
        check_eq("rst_ff", m_first_fail, 0);
        check_eq("rst_vec_idx", m_vec_idx, 0);
        check_eq("rst_exp_idx", m_exp_idx, 0);
        check_eq("rst_aes_state", m_aes_state, 0);
        check_eq("rst_aes_key", m_aes_key, 0);
        check_eq("rst_one_done", o_done, 0);

        // FIPS-197 single vector, clean and with the expected value corrupted
        run_one(1'b0);
        run_one(1'b1);

        // Four-vector runs: clean, vector 2 corrupted, all corrupted (saturation)
        load_main(4'b0000); run_main(1'b0, 1'b0);
        load_main(4'b0100); run_main(1'b0, 1'b0);
        load_main(4'b1111); run_main(1'b0, 1'b0);

        // start pulses during issue must be ignored
        load_main(4'($urandom)); run_main(1'b1, 1'b0);

        // Reset during drain discards in-flight work
        load_main(STOP ? 4'b0000 : 4'b0001);
        @(negedge clk); m_start = 1'b1;
        @(negedge clk); m_start = 1'b0;
        repeat (22) @(negedge clk);
        check_eq("pre_rst_busy", m_busy, 1);
        check_eq("pre_rst_err", m_err_cnt, STOP ? 0 : 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_busy", m_busy, 0);
        check_eq("mid_rst_done", m_done, 0);
        check_eq("mid_rst_err", m_err_cnt, 0);
        check_eq("mid_rst_ff", m_first_fail, 0);
        check_eq("mid_rst_aes", m_aes_state, 0);
        repeat (LAT) @(negedge clk);
        check_eq("rst_no_leak_done", m_done, 0);
        check_eq("rst_no_leak_err", m_err_cnt, 0);
        load_main(4'b0000); run_main(1'b0, 1'b0);

        // Back-to-back: start held on the cycle done rises, done held otherwise
        load_main(4'b0100); run_main(1'b0, 1'b0);
        m_start = 1'b1;
        run_main(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("done_held", m_done, 1);
        check_eq("pass_held", m_pass, 0);

        // Randomized corruption patterns
        for (int it = 0; it < 6; it++) begin
            load_main(4'($urandom));
            run_main(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
